spi_core: RTL and testbench
===========================

# spi_core

SPI master peripheral core for the MMIO subsystem; it attaches to one slot of the MMIO controller (slot 4, the first unused slot) through the standard slot interface. Firmware programs clock divisor and mode, drives the slave-select lines, and writes a byte to start a full-duplex 8-bit transfer. The received byte and a ready flag are read back through the same slot.

## Interface
- S, default 1: number of slave-select outputs (1..32).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- cs  in  1  slot chip select from the MMIO controller.
- read  in  1  slot read strobe (qualified by cs).
- write  in  1  slot write strobe (qualified by cs).
- addr  in  5  slot register address.
- wr_data  in  32  slot write data.
- rd_data  out  32  slot read data (combinational from addr and registers).
- spi_sclk  out  1  serial clock (registered).
- spi_mosi  out  1  master-out data.
- spi_miso  in  1  master-in data.
- spi_ss_n  out  S  active-low slave selects (registered, software-controlled).

## Operation
- Register map (addr[1:0]; addr[4:2] ignored). Writes take effect only when cs&write.
  - 0 read: {23'b0, ready, rx_data[7:0]}. Reads have no side effects.
  - 1 write: spi_ss_n <= wr_data[S-1:0]. Accepted at any time, including mid-transfer.
  - 2 write: dvsr <= wr_data[15:0], cpol <= wr_data[16], cpha <= wr_data[17]. Ignored while ready=0.
  - 3 write: tx byte wr_data[7:0]; starts a transfer if ready=1; ignored while ready=0.
  - Reads of addresses 1-3 return 0.
- Half SCLK period = dvsr+1 clk cycles; a counter runs 0..dvsr in each active state, then advances the FSM.
- FSM states: IDLE, CPHA_DLY, P0, P1.
  - IDLE: ready=1. On an accepted write to reg 3: load tx shift register, clear the rx shift register and bit counter. Go to CPHA_DLY if cpha=1, else P0.
  - CPHA_DLY: one half period, then P0.
  - P0: at the end of the half period, shift spi_miso into the rx shift register LSB (MSB-first), then go to P1.
  - P1: at the end of the half period, if bit count=7, copy the rx shift register into rx_data and go to IDLE. Otherwise shift the tx register left, increment the bit count, and go to P0.
- spi_mosi = tx_shift[7] when not IDLE, else 0; bits are sent MSB first. Bit n is valid from the start of its P0 until the end of its P1.
- Internal pclk = (state==P1) when cpha=0, or (state==P0) when cpha=1. spi_sclk is registered from cpol ^ pclk_next, so it tracks the state with no extra lag. In IDLE, spi_sclk = cpol.
- Result: exactly 8 SCLK pulses per transfer; MISO is sampled on the sampling edge required by the SPI mode, for all four modes.

## Timing
- Reset values: spi_ss_n all 1, spi_sclk 0, spi_mosi 0, ready 1, rx_data 0x00, dvsr 49, cpol 0, cpha 0, state IDLE.
- Start: a reg-3 write sampled at edge k sets ready=0 after edge k.
- Completion: ready returns to 1 and rx_data updates on the same edge, 16·(dvsr+1) edges after k when cpha=0, or 17·(dvsr+1) when cpha=1.
- A reg-3 write in the same cycle that ready rises is accepted; back-to-back transfers need no idle gap.
- Changing spi_miso outside the sampling cycle has no effect.
- Reset asserted mid-transfer: immediate return to reset values. SS lines deassert, no partial rx_data is stored, and no SCLK edge follows.

## Test plan
- Reset: deassert reset -> rd_data at addr 0 = 0x100, spi_ss_n = all 1s, spi_sclk = 0, spi_mosi = 0.
- Loopback (miso tied to mosi), mode 0, dvsr=0: write ss=0, then tx 0xA5 -> ready low for exactly 16 cycles, 8 SCLK pulses, rx_data=0xA5, read of addr 0 = 0x1A5.
- Mode 3 (cpol=1, cpha=1), dvsr=3, slave model returns 0x3C -> SCLK idles high, transfer lasts 68 cycles, rx_data=0x3C, MOSI transitions align with SCLK falling edges.
- Busy writes: during a 0x55 transfer, write tx 0xFF and ctrl dvsr=7 -> both ignored; rx and timing match the 0x55 transfer; dvsr still 0 afterwards.
- Reset mid-transfer: after 5 bits, assert reset for 2 cycles -> all outputs at reset values; next transfer of 0x81 completes normally with rx 0x81.
- Mode 1 and mode 2 loopback at dvsr=1 with pattern 0x96 -> rx 0x96; cycle count is 34 for mode 1 and 32 for mode 2.

Source files
------------

// File: rtl/spi_core.sv
// SPI master core on an MMIO slot: divisor/mode/slave-select registers plus an
// 8-bit full-duplex shifter. Supports all four CPOL/CPHA modes.
module spi_core #(
  parameter int S = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic          spi_sclk,
  output logic          spi_mosi,
  input  logic          spi_miso,
  output logic [S-1:0]  spi_ss_n
);

  // state    | meaning
  // IDLE     | ready, waiting for a tx byte write
  // CPHA_DLY | half-period lead-in used only when cpha=1
  // P0       | first half of a bit; MISO sampled at its end
  // P1       | second half of a bit; shift out next bit or finish
  typedef enum logic [1:0] {IDLE, CPHA_DLY, P0, P1} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_shift;
  logic [7:0]  rx_shift;
  logic [7:0]  rx_data;
  logic [15:0] dvsr;
  logic        cpol;
  logic        cpha;
  logic        sclk_q;
  logic [S-1:0] ss_q;

  logic ready;
  logic wr_ss;
  logic wr_ctrl;
  logic wr_start;
  logic cpol_n;
  logic half_done;

  assign ready     = (state == IDLE);
  assign wr_ss     = cs & write & (addr[1:0] == 2'd1);
  assign wr_ctrl   = cs & write & (addr[1:0] == 2'd2) & ready;
  assign wr_start  = cs & write & (addr[1:0] == 2'd3) & ready;
  assign half_done = (cnt == dvsr);
  // Idle SCLK follows a polarity write in the same edge it is written.
  assign cpol_n    = wr_ctrl ? wr_data[16] : cpol;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      dvsr     <= 16'd49;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
      sclk_q   <= 1'b0;
      ss_q     <= '1;
    end else begin
      if (wr_ss)
        ss_q <= wr_data[S-1:0];
      case (state)
        IDLE: begin
          sclk_q <= cpol_n;
          if (wr_ctrl) begin
            dvsr <= wr_data[15:0];
            cpol <= wr_data[16];
            cpha <= wr_data[17];
          end
          if (wr_start) begin
            tx_shift <= wr_data[7:0];
            rx_shift <= '0;
            bit_cnt  <= '0;
            cnt      <= '0;
            state    <= cpha ? CPHA_DLY : P0;
          end
        end
        CPHA_DLY: begin
          if (half_done) begin
            cnt    <= '0;
            state  <= P0;
            sclk_q <= ~cpol;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        P0: begin
          if (half_done) begin
            cnt      <= '0;
            rx_shift <= {rx_shift[6:0], spi_miso};
            state    <= P1;
            sclk_q   <= cpol ^ ~cpha;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        P1: begin
          if (half_done) begin
            cnt <= '0;
            if (bit_cnt == 3'd7) begin
              rx_data <= rx_shift;
              state   <= IDLE;
              sclk_q  <= cpol;
            end else begin
              tx_shift <= {tx_shift[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
              state    <= P0;
              sclk_q   <= cpol ^ cpha;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr[1:0] == 2'd0)
      rd_data = {23'b0, ready, rx_data};
  end

  assign spi_sclk = sclk_q;
  assign spi_mosi = (state != IDLE) ? tx_shift[7] : 1'b0;
  assign spi_ss_n = ss_q;

  // Read strobe and upper address bits carry no meaning for this slot.
  logic unused_bits;
  assign unused_bits = &{1'b0, read, addr[4:2], wr_data[31:18]};

endmodule

// File: tb/tb_spi_core.sv
// Bench for spi_core: a timing/data model computed from transfer start time,
// divisor and mode is compared against every DUT output on every cycle.
module tb_spi_core;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cs = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [4:0]    addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic          spi_sclk;
  logic          spi_mosi;
  logic          spi_miso;
  logic [S-1:0]  spi_ss_n;

  spi_core #(.S(S)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_ss_n(spi_ss_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // model of programmed state and the transfer in flight
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_T = 0;
  int          m_h = 1;
  bit          m_xcpha = 1'b0;
  logic [15:0] m_dvsr = 16'd49;
  bit          m_cpol = 1'b0;
  bit          m_cpha = 1'b0;
  logic [7:0]  m_tx = '0;
  logic [7:0]  m_rx_prev = '0;
  logic [7:0]  m_rx_new = '0;
  logic [S-1:0] m_ss = '1;
  bit          m_pulse_checked = 1'b1;

  // slave side: loopback or a shift-out byte indexed by SCLK edges seen
  bit          loop_en = 1'b1;
  logic [7:0]  slv_byte = '0;
  int          edges = 0;
  int          pulses = 0;
  logic        prev_sclk = 1'b0;
  int          slave_idx;

  always_comb begin
    slave_idx = m_xcpha ? ((edges == 0) ? 0 : (edges - 1) / 2) : edges / 2;
    if (slave_idx > 7) slave_idx = 7;
  end
  assign spi_miso = loop_en ? spi_mosi : slv_byte[3'(7 - slave_idx)];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_active = 1'b0;
    m_dvsr = 16'd49;
    m_cpol = 1'b0;
    m_cpha = 1'b0;
    m_xcpha = 1'b0;
    m_rx_prev = '0;
    m_rx_new = '0;
    m_ss = '1;
    m_pulse_checked = 1'b1;
  endtask

  task automatic m_write(input logic [1:0] a, input logic [31:0] d, input bit en);
    bit idle_prev;
    idle_prev = !(m_active && (cyc - 1 - m_k) < m_T);
    if (en) begin
      case (a)
        2'd1: m_ss = d[S-1:0];
        2'd2: if (idle_prev) begin
          m_dvsr = d[15:0];
          m_cpol = d[16];
          m_cpha = d[17];
        end
        2'd3: if (idle_prev) begin
          if (m_active) m_rx_prev = m_rx_new;
          m_active = 1'b1;
          m_k = cyc;
          m_h = int'(m_dvsr) + 1;
          m_xcpha = m_cpha;
          m_T = (16 + (m_cpha ? 1 : 0)) * m_h;
          m_tx = d[7:0];
          m_rx_new = loop_en ? d[7:0] : slv_byte;
          edges = 0;
          pulses = 0;
          m_pulse_checked = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin : cmp
    int t, p, q, b;
    logic exp_sclk, exp_mosi, exp_ready;
    logic [7:0] exp_rx;
    if (spi_sclk !== prev_sclk) begin
      edges++;
      if (spi_sclk !== m_cpol) pulses++;
    end
    prev_sclk = spi_sclk;
    t = cyc - m_k;
    if (m_active && t < m_T) begin
      p = t / m_h;
      exp_ready = 1'b0;
      exp_rx = m_rx_prev;
      if (m_xcpha && p == 0) begin
        exp_sclk = m_cpol;
        exp_mosi = m_tx[7];
      end else begin
        q = p - (m_xcpha ? 1 : 0);
        b = q / 2;
        exp_sclk = m_cpol ^ (m_xcpha ? (q % 2 == 0) : (q % 2 == 1));
        exp_mosi = m_tx[3'(7 - b)];
      end
    end else begin
      exp_ready = 1'b1;
      exp_sclk = m_cpol;
      exp_mosi = 1'b0;
      exp_rx = m_active ? m_rx_new : m_rx_prev;
      if (m_active && !m_pulse_checked) begin
        chk("sclk_pulses", pulses, 8);
        m_pulse_checked = 1'b1;
      end
    end
    chk("sclk", {31'b0, spi_sclk}, {31'b0, exp_sclk});
    chk("mosi", {31'b0, spi_mosi}, {31'b0, exp_mosi});
    chk("ss_n", {{(32-S){1'b0}}, spi_ss_n}, {{(32-S){1'b0}}, m_ss});
    chk("rd_data", rd_data, (addr[1:0] == 2'd0) ? {23'b0, exp_ready, exp_rx} : 32'h0);
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input bit en);
    cs = en;
    write = 1'b1;
    addr = {3'($urandom_range(0, 7)), a};
    wr_data = d;
    @(posedge clk);
    #1;
    m_write(a, d, en);
    cs = 1'b0;
    write = 1'b0;
    addr = {3'($urandom_range(0, 7)), 2'b00};
    wr_data = $urandom;
  endtask

  task automatic bus_read(input logic [1:0] a);
    cs = 1'b1;
    read = 1'b1;
    addr = {3'($urandom_range(0, 7)), a};
    @(posedge clk);
    #1;
    cs = 1'b0;
    read = 1'b0;
    addr = '0;
  endtask

  task automatic wait_done(output int n);
    bit ok;
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (rd_data[8] === 1'b1) ok = 1'b1;
      else n++;
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1 reset = 1'b0;
    m_reset();
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0] md;
    logic [15:0] dv;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_rd", rd_data, 32'h100);
    chk("rst_ss", {28'b0, spi_ss_n}, 32'hF);
    chk("rst_sclk", {31'b0, spi_sclk}, 32'h0);
    chk("rst_mosi", {31'b0, spi_mosi}, 32'h0);
    #1;

    // mode 0 loopback, dvsr 0
    loop_en = 1'b1;
    bus_write(2'd2, 32'h0, 1'b1);
    bus_write(2'd1, 32'h0, 1'b1);
    bus_write(2'd3, 32'hA5, 1'b1);
    wait_done(n);
    chk("m0_len", n, 16);
    chk("m0_pulses", pulses, 8);
    chk("m0_rd", rd_data, 32'h1A5);

    // mode 3, dvsr 3, slave returns 0x3C
    loop_en = 1'b0;
    slv_byte = 8'h3C;
    bus_write(2'd2, 32'h0003_0003, 1'b1);
    bus_write(2'd3, 32'h5A, 1'b1);
    wait_done(n);
    chk("m3_len", n, 68);
    chk("m3_rd", rd_data, 32'h13C);
    chk("m3_idle_sclk", {31'b0, spi_sclk}, 32'h1);

    // busy writes ignored
    loop_en = 1'b1;
    bus_write(2'd2, 32'h0, 1'b1);
    bus_write(2'd3, 32'h55, 1'b1);
    bus_write(2'd3, 32'hFF, 1'b1);
    bus_write(2'd2, 32'h7, 1'b1);
    wait_done(n);
    chk("busy_len", n, 14);
    chk("busy_rd", rd_data, 32'h155);
    bus_write(2'd3, 32'h33, 1'b1);
    wait_done(n);
    chk("busy_dvsr_kept", n, 16);

    // back-to-back: start in the cycle ready rises
    bus_write(2'd3, 32'hC6, 1'b1);
    wait_done(n);
    bus_write(2'd3, 32'h19, 1'b1);
    wait_done(n);
    chk("b2b_len", n, 16);
    chk("b2b_rd", rd_data, 32'h119);

    // reset mid-transfer after 5 bits
    bus_write(2'd3, 32'hC3, 1'b1);
    repeat (10) @(posedge clk);
    do_reset(2);
    @(negedge clk);
    chk("mrst_rd", rd_data, 32'h100);
    chk("mrst_ss", {28'b0, spi_ss_n}, 32'hF);
    chk("mrst_sclk", {31'b0, spi_sclk}, 32'h0);
    chk("mrst_mosi", {31'b0, spi_mosi}, 32'h0);
    #1;
    bus_write(2'd1, 32'h0, 1'b1);
    bus_write(2'd3, 32'h81, 1'b1);
    wait_done(n);
    chk("mrst_len", n, 800);
    chk("mrst_rd2", rd_data, 32'h181);

    // mode 1 and mode 2 loopback, dvsr 1
    bus_write(2'd2, 32'h0002_0001, 1'b1);
    bus_write(2'd3, 32'h96, 1'b1);
    wait_done(n);
    chk("m1_len", n, 34);
    chk("m1_rd", rd_data, 32'h196);
    bus_write(2'd2, 32'h0001_0001, 1'b1);
    bus_write(2'd3, 32'h96, 1'b1);
    wait_done(n);
    chk("m2_len", n, 32);
    chk("m2_rd", rd_data, 32'h196);

    // randomized transfers
    for (int it = 0; it < 40; it++) begin
      dv = 16'($urandom_range(0, 3));
      md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus_write(2'd3, $urandom, 1'b0);
      bus_write(2'd2, {14'b0, md[0], md[1], dv}, 1'b1);
      bus_write(2'd1, $urandom, 1'b1);
      loop_en = 1'($urandom_range(0, 1));
      slv_byte = 8'($urandom);
      bus_write(2'd3, $urandom, 1'b1);
      if ($urandom_range(0, 1) == 1) bus_write(2'($urandom_range(2, 3)), $urandom, 1'b1);
      if ($urandom_range(0, 1) == 1) bus_write(2'd1, $urandom, 1'b1);
      if ($urandom_range(0, 1) == 1) bus_read(2'($urandom_range(1, 3)));
      wait_done(n);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
